// File: rtl/judge_pkg.sv
// Shared definitions for the judge sequencer: FSM state encoding and
// the latency limits of the compare pipeline.
package judge_pkg;

    // Largest supported DUT/golden latency in cycles.
    localparam int LAT_MAX = 8;

    // Width of the drain cycle counter (must hold LAT_MAX - 1).
    localparam int DRAIN_W = 4;

    // Run sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_REPORT = 2'b11
    } state_t;

endpackage

// File: rtl/judge_delay_line.sv
// LAT-stage shift register carrying {valid, idx} of each issued stimulus
// step so the comparator knows which step the current DUT/golden output
// pair belongs to. Cleared synchronously by rst.
module judge_delay_line #(
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] in_idx,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_idx
);

    logic             valid_r [LAT];
    logic [CNT_W-1:0] idx_r   [LAT];

    // Shift the issued step tag one stage per cycle; rst empties every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                valid_r[i] <= 1'b0;
                idx_r[i]   <= {CNT_W{1'b0}};
            end
        end else begin
            valid_r[0] <= in_valid;
            idx_r[0]   <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
                idx_r[i]   <= idx_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[LAT-1];
    assign out_idx   = idx_r[LAT-1];

endmodule

// File: rtl/judge_sequencer.sv
// Sequences one judged run: issues num_steps stimulus strobes, compares
// the masked DUT output with the golden output LAT cycles later, counts
// mismatching samples (saturating), remembers the first failing step and
// presents a pass/fail verdict until the collector accepts it.
//
// Build option: define STOP_ON_FIRST_MISMATCH_EN to stop issuing stimulus
// as soon as the first mismatch is seen; samples already in flight are
// still compared and counted.
module judge_sequencer
    import judge_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_steps,
    input  logic [DW-1:0]    dut_y,
    input  logic [DW-1:0]    ref_y,
    input  logic [DW-1:0]    cmp_mask,
    output logic             stim_en,
    output logic [CNT_W-1:0] stim_idx,
    output logic             busy,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err,
    output logic             res_valid,
    output logic             res_pass,
    input  logic             res_ready
);

    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ALL1   = {CNT_W{1'b1}};
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};
    // Last drain cycle: the final in-flight sample is compared in it.
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LAT - 1);

    // A sample mismatches when any compared bit differs.
    function automatic logic masked_diff(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] m
    );
        return |((a ^ b) & m);
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   num_r;
    logic [DW-1:0]      mask_r;
    logic [DRAIN_W-1:0] drain_r;

    logic               dly_valid_s;
    logic [CNT_W-1:0]   dly_idx_s;
    logic               cmp_mis_s;
    logic [CNT_W-1:0]   err_next_s;
    logic               last_step_s;
    logic               stop_s;

    judge_delay_line #(
        .LAT   (LAT),
        .CNT_W (CNT_W)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (stim_en),
        .in_idx    (stim_idx),
        .out_valid (dly_valid_s),
        .out_idx   (dly_idx_s)
    );

    // Compare the output pair belonging to the step that left the delay line.
    always_comb begin
        cmp_mis_s = 1'b0;
        if (dly_valid_s) begin
            cmp_mis_s = masked_diff(dut_y, ref_y, mask_r);
        end else begin
            cmp_mis_s = 1'b0;
        end
    end

    // Next error count, pinned at all-ones once saturated.
    always_comb begin
        err_next_s = err_count;
        if (cmp_mis_s && (err_count != CNT_ALL1)) begin
            err_next_s = err_count + CNT_ONE;
        end else begin
            err_next_s = err_count;
        end
    end

    assign last_step_s = (stim_idx == (num_r - CNT_ONE));

`ifdef STOP_ON_FIRST_MISMATCH_EN
    assign stop_s = cmp_mis_s;
`else
    assign stop_s = 1'b0;
`endif

    // Run FSM with registered strobes, counters and verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            num_r     <= CNT_ZERO;
            mask_r    <= {DW{1'b0}};
            drain_r   <= DRAIN_ZERO;
            stim_en   <= 1'b0;
            stim_idx  <= CNT_ZERO;
            busy      <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= CNT_ZERO;
            first_err <= CNT_ZERO;
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
        end else begin
            // Compare results are folded in every cycle; the delay line is
            // empty outside RUN/DRAIN so nothing changes there.
            mismatch  <= cmp_mis_s;
            err_count <= err_next_s;
            if (cmp_mis_s && (err_count == CNT_ZERO)) begin
                first_err <= dly_idx_s;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_r     <= num_steps;
                        mask_r    <= cmp_mask;
                        err_count <= CNT_ZERO;
                        first_err <= CNT_ZERO;
                        busy      <= 1'b1;
                        if (num_steps == CNT_ZERO) begin
                            // Empty run: verdict is an immediate pass.
                            state_r   <= ST_REPORT;
                            res_valid <= 1'b1;
                            res_pass  <= 1'b1;
                        end else begin
                            state_r  <= ST_RUN;
                            stim_en  <= 1'b1;
                            stim_idx <= CNT_ZERO;
                        end
                    end
                end

                ST_RUN: begin
                    if (last_step_s || stop_s) begin
                        state_r  <= ST_DRAIN;
                        stim_en  <= 1'b0;
                        stim_idx <= CNT_ZERO;
                        drain_r  <= DRAIN_ZERO;
                    end else begin
                        stim_idx <= stim_idx + CNT_ONE;
                    end
                end

                ST_DRAIN: begin
                    if (drain_r == DRAIN_LAST) begin
                        // Last in-flight sample is being compared now, so
                        // the verdict uses the updated count.
                        state_r   <= ST_REPORT;
                        res_valid <= 1'b1;
                        res_pass  <= (err_next_s == CNT_ZERO);
                    end else begin
                        drain_r <= drain_r + DRAIN_ONE;
                    end
                end

                ST_REPORT: begin
                    if (res_ready) begin
                        // start in this cycle is deliberately not accepted.
                        state_r   <= ST_IDLE;
                        res_valid <= 1'b0;
                        res_pass  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    stim_en   <= 1'b0;
                    stim_idx  <= CNT_ZERO;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    res_pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule
